// File: rtl/bulls_cows_pkg.sv
// Shared types, constants and the BCD guess/secret legality check for the
// Bulls & Cows game.
package bulls_cows_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_DIGIT  = 9;

  // True when all four nibbles are decimal digits and no digit repeats.
  function automatic logic digits_valid(input logic [15:0] value);
    logic [3:0] digit [NUM_DIGITS];
    logic       ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit[i] = value[4*i +: 4];
      if (digit[i] > 4'(MAX_DIGIT)) ok = 1'b0;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (digit[i] == digit[j]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/guess_validator.sv
// Combinational legality check of a four-digit BCD guess.
module guess_validator
  import bulls_cows_pkg::*;
(
  input  logic [15:0] value,
  output logic        ok
);

  assign ok = digits_valid(value);

endmodule

// File: rtl/guess_input_ctrl.sv
// Synchronizes and debounces the confirm button and turns each accepted press
// into a single guess_valid or guess_error pulse based on the switch value.
module guess_input_ctrl
  import bulls_cows_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        CPU_RESETN,
  input  logic        confirm,
  input  logic [15:0] SW,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic        guess_error,
  output logic        confirm_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic        conf_meta_q, conf_s_q;
  logic [15:0] sw_meta_q, sw_s_q;
  logic        sw_ok;

  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic [15:0]      guess_q, guess_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two-stage synchronizer.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      conf_meta_q <= 1'b0;
      conf_s_q    <= 1'b0;
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
    end else begin
      conf_meta_q <= confirm;
      conf_s_q    <= conf_meta_q;
      sw_meta_q   <= SW;
      sw_s_q      <= sw_meta_q;
    end
  end

  guess_validator u_validator (
    .value (sw_s_q),
    .ok    (sw_ok)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    guess_d = guess_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (conf_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!conf_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!conf_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A return to high inside the window is a bounce: no new event.
        if (conf_s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (sw_ok) begin
        guess_d = sw_s_q;
        valid_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      guess_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      guess_q <= guess_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign guess         = guess_q;
  assign guess_valid   = valid_q;
  assign guess_error   = error_q;
  assign confirm_level = level_q;

endmodule

// File: tb/tb_guess_input_ctrl.sv
// Scoreboard bench for guess_input_ctrl: a run-length debounce model predicts
// events into a queue; a negedge monitor pops and compares DUT pulses.
module tb_guess_input_ctrl;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        CPU_RESETN;
  logic        confirm;
  logic [15:0] SW;
  logic [15:0] guess;
  logic        guess_valid;
  logic        guess_error;
  logic        confirm_level;

  always #5 clock = ~clock;

  guess_input_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clock         (clock),
    .CPU_RESETN    (CPU_RESETN),
    .confirm       (confirm),
    .SW            (SW),
    .guess         (guess),
    .guess_valid   (guess_valid),
    .guess_error   (guess_error),
    .confirm_level (confirm_level)
  );

  typedef struct {
    bit          is_valid;
    logic [15:0] value;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_item;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ev_count    = 0;

  // Reference model state: two-sample input delay, debounced level and the
  // length of the current run of samples that disagree with that level.
  logic        m_c1, m_c2;
  logic [15:0] m_s1, m_s2;
  logic        m_level;
  int          m_run;
  logic [15:0] m_guess;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_valid(input logic [15:0] v);
    bit [15:0] seen = '0;
    for (int i = 0; i < 4; i++) begin
      int dig = int'(v[4*i +: 4]);
      if (dig > 9 || seen[dig]) return 1'b0;
      seen[dig] = 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] gen_sw();
    int pool[10];
    logic [15:0] v;
    if ($urandom_range(0, 2) == 0) return 16'($urandom);
    for (int i = 0; i < 10; i++) pool[i] = i;
    for (int i = 0; i < 4; i++) begin
      int j = $urandom_range(i, 9);
      int t = pool[i];
      pool[i] = pool[j];
      pool[j] = t;
      v[4*i +: 4] = 4'(pool[i]);
    end
    return v;
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      m_c1 = 1'b0; m_c2 = 1'b0; m_s1 = '0; m_s2 = '0;
      m_level = 1'b0; m_run = 0; m_guess = '0;
      exp_q.delete();
    end else begin
      // A level change needs D+1 consecutive disagreeing synchronized samples.
      if (m_c2 != m_level) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) begin
          if (ref_valid(m_s2)) begin
            m_guess = m_s2;
            exp_q.push_back('{1'b1, m_s2});
          end else begin
            exp_q.push_back('{1'b0, m_guess});
          end
        end
      end
      m_c2 = m_c1; m_c1 = confirm;
      m_s2 = m_s1; m_s1 = SW;
    end
  end

  always @(negedge clock) begin
    check("confirm_level", confirm_level, m_level);
    check("guess_value", guess, m_guess);
    if (guess_valid || guess_error) begin
      ev_count++;
      if (exp_q.size() == 0) begin
        check("spurious_event", {guess_valid, guess_error}, 2'b00);
      end else begin
        exp_item = exp_q.pop_front();
        check("event_kind", {guess_valid, guess_error}, exp_item.is_valid ? 2'b10 : 2'b01);
        check("event_guess", guess, exp_item.value);
      end
    end else if (exp_q.size() != 0) begin
      check("missed_event", {guess_valid, guess_error}, exp_q[0].is_valid ? 2'b10 : 2'b01);
      exp_q.delete();
    end
  end

  // Press with a given SW, hold for `hold` cycles, release and settle.
  task automatic press(input logic [15:0] sw, input int hold,
                       output int n_valid, output int n_error, output int lat);
    int k;
    n_valid = 0; n_error = 0; lat = -1;
    @(negedge clock);
    SW = sw; confirm = 1'b1; k = cyc + 1;
    repeat (hold) begin
      @(negedge clock);
      if (guess_valid) n_valid++;
      if (guess_error) n_error++;
      if ((guess_valid || guess_error) && lat < 0) lat = cyc - k;
    end
    confirm = 1'b0;
    repeat (3 * D + 4) begin
      @(negedge clock);
      if (guess_valid) n_valid++;
      if (guess_error) n_error++;
    end
  endtask

  int nv, ne, lat, ev0, f, fall_at, k;

  initial begin
    CPU_RESETN = 1'b0; confirm = 1'b0; SW = '0;
    repeat (3) @(negedge clock);
    check("reset_guess", guess, 16'h0000);
    check("reset_pulses", {guess_valid, guess_error, confirm_level}, 3'b000);
    #2 CPU_RESETN = 1'b1;
    repeat (2) @(negedge clock);

    // 1: valid guess, held 20 cycles
    press(16'h1234, 20, nv, ne, lat);
    check("t1_valid_count", nv, 1);
    check("t1_error_count", ne, 0);
    check("t1_latency", lat, 2 + D);
    check("t1_guess", guess, 16'h1234);

    // 2: repeated digit
    press(16'h1123, 20, nv, ne, lat);
    check("t2_valid_count", nv, 0);
    check("t2_error_count", ne, 1);
    check("t2_guess_held", guess, 16'h1234);

    // 3: non-decimal nibble, then a valid guess with a zero digit
    press(16'h12A4, 20, nv, ne, lat);
    check("t3a_error_count", ne, 1);
    check("t3a_valid_count", nv, 0);
    press(16'h9870, 20, nv, ne, lat);
    check("t3b_valid_count", nv, 1);
    check("t3b_guess", guess, 16'h9870);

    // 4: single-cycle glitches, then stable high
    SW = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      confirm = (i % 2 == 0);
    end
    press(16'h5678, 20, nv, ne, lat);
    check("t4_valid_count", nv, 1);
    check("t4_latency", lat, 2 + D);

    // 5: long hold, release bounce, final release
    ev0 = ev_count;
    @(negedge clock); SW = 16'h0159; confirm = 1'b1;
    repeat (100) @(negedge clock);
    confirm = 1'b0; repeat (2) @(negedge clock);
    confirm = 1'b1; repeat (2) @(negedge clock);
    check("t5_level_through_bounce", confirm_level, 1'b1);
    confirm = 1'b0; f = cyc + 1; fall_at = -1;
    repeat (10) begin
      @(negedge clock);
      if (!confirm_level && fall_at < 0) fall_at = cyc - f;
    end
    check("t5_event_count", ev_count - ev0, 1);
    check("t5_level_fall", fall_at, 2 + D);

    // 6: reset during PRESS_WAIT with confirm still high afterwards
    @(negedge clock); SW = 16'h4321; confirm = 1'b1;
    repeat (4) @(negedge clock);
    #2 CPU_RESETN = 1'b0;
    @(negedge clock);
    check("t6_reset_outputs", {guess, guess_valid, guess_error, confirm_level}, 19'h0);
    @(negedge clock);
    #2 CPU_RESETN = 1'b1; k = cyc + 1; lat = -1;
    for (int i = 0; i < 4 * D + 10 && lat < 0; i++) begin
      @(negedge clock);
      if (guess_valid) lat = cyc - k;
    end
    check("t6_latency", lat, 2 + D);
    repeat (10) @(negedge clock);
    confirm = 1'b0;
    repeat (3 * D + 4) @(negedge clock);

    // Random confirm runs with random switches, some changing mid-window
    for (int seg = 0; seg < 150; seg++) begin
      int len = $urandom_range(1, 3 * D);
      confirm = $urandom_range(0, 1);
      SW = gen_sw();
      repeat (len) begin
        @(negedge clock);
        if ($urandom_range(0, 7) == 0) SW = gen_sw();
      end
    end
    confirm = 1'b0;
    repeat (3 * D + 6) @(negedge clock);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
